// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and constants for the shift sequencer
//
// Purpose : FSM state encoding, per-cycle step limit and the request
//           command bundle used by the shift sequencer and its users.
// Ports   : none (package).

package shift_seq_pkg;

   // Largest shift the downstream barrel shifter performs in one cycle;
   // bounded by its 2-bit shift_value input.
   localparam int MAX_STEP = 3;

   // Width of the amount field carried in shift_cmd_t.
   localparam int CMD_AMT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic                 select;     // 0=shift, 1=rotate
      logic                 direction;  // 0=right, 1=left
      logic [CMD_AMT_W-1:0] amount;     // total bit positions to move
      logic [3:0]           data;       // operand
   } shift_cmd_t;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - 4-bit combinational barrel shifter, 0..3 positions
//
// Purpose : single-cycle shift or rotate of a 4-bit operand.
// Ports   : select      - 0=logical shift (zero fill), 1=rotate
//           direction   - 0=right, 1=left
//           shift_value - positions to move, 0..3
//           din         - operand
//           dout        - result (combinational)

module barrel_shifter (
   input  logic       select,
   input  logic       direction,
   input  logic [1:0] shift_value,
   input  logic [3:0] din,
   output logic [3:0] dout
);

   logic [3:0] rot_left;
   logic [3:0] rot_right;

   always_comb begin
      rot_left = din;
      case (shift_value)
         2'd0: rot_left = din;
         2'd1: rot_left = {din[2:0], din[3]};
         2'd2: rot_left = {din[1:0], din[3:2]};
         2'd3: rot_left = {din[0],   din[3:1]};
         default: rot_left = din;
      endcase
   end

   always_comb begin
      rot_right = din;
      case (shift_value)
         2'd0: rot_right = din;
         2'd1: rot_right = {din[0],   din[3:1]};
         2'd2: rot_right = {din[1:0], din[3:2]};
         2'd3: rot_right = {din[2:0], din[3]};
         default: rot_right = din;
      endcase
   end

   always_comb begin
      dout = din;
      case ({select, direction})
         2'b00: dout = din >> shift_value;
         2'b01: dout = din << shift_value;
         2'b10: dout = rot_right;
         2'b11: dout = rot_left;
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - splits a 0..15 shift/rotate into barrel-shifter steps
//
// Purpose : accepts a shift/rotate request, drives an external 4-bit barrel
//           shifter one step (at most MAX_STEP positions) per cycle, feeding
//           each result back, and returns the final value.
// Ports   : clk, rst_n          - clock, async active-low reset
//           req_valid/req_ready - request handshake
//           req_select          - 0=shift, 1=rotate
//           req_direction       - 0=right, 1=left
//           req_amount          - total positions to move
//           req_data            - operand
//           bs_select, bs_direction, bs_shift_value, bs_din
//                               - drive to the barrel shifter
//           bs_dout             - combinational return from the barrel shifter
//           rsp_valid/rsp_ready - response handshake
//           rsp_data            - final result
//           busy                - high while a request is in flight

module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_select,
   input  logic             req_direction,
   input  logic [AMT_W-1:0] req_amount,
   input  logic [3:0]       req_data,
   output logic             bs_select,
   output logic             bs_direction,
   output logic [1:0]       bs_shift_value,
   output logic [3:0]       bs_din,
   input  logic [3:0]       bs_dout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_data,
   output logic             busy
);

   state_t           state;
   logic [3:0]       work;
   logic [AMT_W-1:0] remaining;
   logic             sel;
   logic             dir;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic             busy_q;

   // Size of the step taken this cycle: min(remaining, MAX_STEP).
   logic [1:0]       step;
   logic             last_step;

   always_comb begin
      step = remaining[1:0];
      if (remaining > AMT_W'(MAX_STEP)) begin
         step = 2'(MAX_STEP);
      end
   end

   assign last_step = (remaining == AMT_W'(step));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         work        <= 4'b0000;
         remaining   <= '0;
         sel         <= 1'b0;
         dir         <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  work        <= req_data;
                  remaining   <= req_amount;
                  sel         <= req_select;
                  dir         <= req_direction;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (req_amount == '0) begin
                     state       <= RESP;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state <= STEP;
                  end
               end
            end
            STEP: begin
               work      <= bs_dout;
               remaining <= remaining - AMT_W'(step);
               if (last_step) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
               end
            end
            RESP: begin
               // The request port only reopens after this edge, so a request
               // presented alongside rsp_ready is taken one cycle later.
               if (rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign busy           = busy_q;
   assign rsp_data       = work;
   assign bs_din         = work;
   assign bs_select      = sel;
   assign bs_direction   = dir;
   assign bs_shift_value = (state == STEP) ? step : 2'd0;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer + barrel_shifter

module tb_shift_sequencer;
   import shift_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_select = 1'b0;
   logic       req_direction = 1'b0;
   logic [3:0] req_amount = 4'd0;
   logic [3:0] req_data = 4'd0;
   logic       bs_select;
   logic       bs_direction;
   logic [1:0] bs_shift_value;
   logic [3:0] bs_din;
   logic [3:0] bs_dout;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_data;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.AMT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_select(req_select), .req_direction(req_direction),
      .req_amount(req_amount), .req_data(req_data),
      .bs_select(bs_select), .bs_direction(bs_direction),
      .bs_shift_value(bs_shift_value), .bs_din(bs_din), .bs_dout(bs_dout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy)
   );

   barrel_shifter u_bs (
      .select(bs_select), .direction(bs_direction),
      .shift_value(bs_shift_value), .din(bs_din), .dout(bs_dout)
   );

   // Reference: the value after moving d by amt positions in one go.
   function automatic logic [3:0] ref_move(input logic s, input logic d_left,
                                           input int amt, input logic [3:0] d);
      logic [7:0] dd;
      logic [3:0] r;
      int         k;
      if (!s) begin
         if (amt >= 4) return 4'b0000;
         r = d_left ? (d << amt) : (d >> amt);
         return r;
      end
      k  = amt % 4;
      dd = {d, d};
      if (d_left) begin
         dd = dd << k;
         r  = dd[7:4];
      end else begin
         dd = dd >> k;
         r  = dd[3:0];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
   task automatic send(input shift_cmd_t c);
      chk("req_ready_before_send", 8'(req_ready), 8'd1);
      req_valid     = 1'b1;
      req_select    = c.select;
      req_direction = c.direction;
      req_amount    = c.amount;
      req_data      = c.data;
      @(negedge clk);
      req_valid     = 1'b0;
   endtask

   // Checks every STEP cycle; returns at the negedge of the first RESP cycle.
   task automatic check_steps(input shift_cmd_t c);
      int rem = int'(c.amount);
      int cum = 0;
      int s;
      while (rem > 0) begin
         s = (rem > MAX_STEP) ? MAX_STEP : rem;
         chk("step_value", 8'(bs_shift_value), 8'(s));
         chk("step_din", 8'(bs_din), 8'(ref_move(c.select, c.direction, cum, c.data)));
         chk("step_sel_dir", 8'({bs_select, bs_direction}), 8'({c.select, c.direction}));
         chk("step_flags", 8'({busy, req_ready, rsp_valid}), 8'b100);
         cum += s;
         rem -= s;
         @(negedge clk);
      end
   endtask

   // Holds rsp_ready low for 'hold' cycles, then completes the handshake.
   task automatic check_resp(input shift_cmd_t c, input int hold);
      logic [3:0] exp = ref_move(c.select, c.direction, int'(c.amount), c.data);
      for (int h = 0; h <= hold; h++) begin
         chk("resp_valid", 8'(rsp_valid), 8'd1);
         chk("resp_data", 8'(rsp_data), 8'(exp));
         chk("resp_flags", 8'({busy, req_ready, bs_shift_value}), 8'b1000);
         if (h < hold) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("after_resp_idle", 8'({rsp_valid, req_ready, busy}), 8'b010);
   endtask

   task automatic run(input shift_cmd_t c, input int hold);
      send(c);
      check_steps(c);
      check_resp(c, hold);
   endtask

   initial begin
      shift_cmd_t c;
      shift_cmd_t c2;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_flags", 8'({req_ready, rsp_valid, busy}), 8'b100);
      chk("reset_bs", 8'({bs_shift_value, bs_din}), 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_flags", 8'({req_ready, rsp_valid, busy}), 8'b100);

      // Rotate left 5 of 1001: steps 3,2, intermediate 1100, result 0011
      c = '{select: 1'b1, direction: 1'b1, amount: 4'd5, data: 4'b1001};
      run(c, 1);
      // Shift right 4 of 1111: steps 3,1, intermediate 0001, result 0000
      c = '{select: 1'b0, direction: 1'b0, amount: 4'd4, data: 4'b1111};
      run(c, 0);
      // Shift left 0 of 1010: no STEP cycle
      c = '{select: 1'b0, direction: 1'b1, amount: 4'd0, data: 4'b1010};
      run(c, 2);
      // Rotate right 15 of 0110: five steps of 3, result 1100
      c = '{select: 1'b1, direction: 1'b0, amount: 4'd15, data: 4'b0110};
      run(c, 0);
      chk("rotr15_literal", 8'(ref_move(1'b1, 1'b0, 15, 4'b0110)), 8'b1100);

      // Backpressure with a second request pending during RESP
      c  = '{select: 1'b0, direction: 1'b1, amount: 4'd2, data: 4'b0111};
      c2 = '{select: 1'b1, direction: 1'b1, amount: 4'd7, data: 4'b0001};
      send(c);
      check_steps(c);
      req_valid     = 1'b1;
      req_select    = c2.select;
      req_direction = c2.direction;
      req_amount    = c2.amount;
      req_data      = c2.data;
      for (int h = 0; h < 4; h++) begin
         chk("bp_valid", 8'(rsp_valid), 8'd1);
         chk("bp_data", 8'(rsp_data), 8'(ref_move(c.select, c.direction, 2, c.data)));
         chk("bp_req_ready", 8'(req_ready), 8'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_idle", 8'({req_ready, busy, rsp_valid}), 8'b100);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_second_taken", 8'({req_ready, busy}), 8'b01);
      check_steps(c2);
      check_resp(c2, 0);

      // Reset in STEP during rotate-left-9
      c = '{select: 1'b1, direction: 1'b1, amount: 4'd9, data: 4'b0101};
      send(c);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_flags", 8'({req_ready, rsp_valid, busy}), 8'b100);
      chk("rst_mid_work", 8'({rsp_data, bs_din}), 8'h00);
      chk("rst_mid_step", 8'(bs_shift_value), 8'd0);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rst_no_resp", 8'({rsp_valid, busy, req_ready}), 8'b001);
      end
      rsp_ready = 1'b0;

      // Randomized requests against the reference model
      for (int i = 0; i < 30; i++) begin
         c.select    = 1'($urandom);
         c.direction = 1'($urandom);
         c.amount    = 4'($urandom_range(0, 15));
         c.data      = 4'($urandom);
         run(c, int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1);
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Upstream command stage for the 4-bit barrel shifter. Accepts a shift/rotate request with an amount of 0–15 over a valid/ready handshake. Breaks the amount into steps of at most 3 and drives the barrel shifter one step per cycle, feeding each step's output back as the next step's input. Returns the final 4-bit result over a second valid/ready handshake.

Parameters:
AMT_W, 4, width of the requested shift amount; maximum amount is 2^AMT_W-1.
MAX_STEP, 3, largest per-cycle shift the barrel shifter supports; fixed by its 2-bit shift_value.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_select  input  1  0=shift, 1=rotate
req_direction  input  1  0=right, 1=left
req_amount  input  AMT_W  total bit positions to move
req_data  input  4  operand
bs_select  output  1  to barrel_shifter select
bs_direction  output  1  to barrel_shifter direction
bs_shift_value  output  2  to barrel_shifter shift_value
bs_din  output  4  to barrel_shifter din
bs_dout  input  4  from barrel_shifter dout; combinational return path
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_data  output  4  final result
busy  output  1  high in STEP or RESP

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, work=4'b0000, remaining=0, sel=0, dir=0, rsp_valid=0, busy=0, req_ready=1 (req_ready = state==IDLE), bs_shift_value=0.
- Registers: work[3:0], remaining[AMT_W-1:0], sel, dir, and the FSM state.
- FSM states: IDLE, STEP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch work=req_data, remaining=req_amount, sel=req_select, dir=req_direction.
  - If req_amount==0, go to RESP; otherwise go to STEP.
- STEP:
  - step = min(remaining, MAX_STEP).
  - Drive bs_shift_value=step, bs_din=work, bs_select=sel, bs_direction=dir.
  - At the clock edge: work<=bs_dout, remaining<=remaining-step.
  - If remaining==step, go to RESP; otherwise stay in STEP.
- RESP:
  - rsp_valid=1, rsp_data=work.
  - Hold both stable until rsp_ready=1, then go to IDLE. rsp_ready and req_valid in the same cycle do not overlap: the new request is taken in IDLE on the next cycle.
- Outside STEP: bs_shift_value=0; bs_din, bs_select and bs_direction show the registered values.
- Latency:
  - The request is accepted at edge N.
  - rsp_valid rises after edge N+ceil(amount/3)+1 - 1, i.e. amount 0 gives rsp_valid in cycle N+1, and amounts 1–3 give it in cycle N+2.
  - STEP lasts exactly ceil(amount/3) cycles.
- No rotate modulo optimisation and no shift-to-zero short-circuit. Latency depends only on amount.
- Shift mode: bits shifted out are lost and zeros are filled in, per the barrel shifter. Iterating this is equivalent to a single shift by the total amount; amounts ≥4 give 0000.
- Rotate mode: the result equals a rotate by amount mod 4.
- req_ready=0 in STEP and RESP. req_* inputs are ignored while busy.
- Reset mid-operation: any state returns to IDLE immediately and the in-flight request is dropped, with no response. rsp_valid falls asynchronously.
- rsp_valid must never drop without a handshake, except on reset.

Decomposition:
- Package shift_seq_pkg holds:
  - state_t enum {IDLE, STEP, RESP}
  - localparam MAX_STEP=3
  - struct shift_cmd_t {select, direction, amount, data}
- No sub-module. The barrel_shifter is instantiated alongside this block at the level above and connected through the bs_* ports. The bench instantiates both.

Test Plan:
- Rotate left, amount 5, data 1001:
  - Expect step 3 then step 2.
  - Expect intermediate work 1100.
  - Expect rsp_data=0011, with rsp_valid 3 cycles after acceptance.
- Shift right, amount 4, data 1111: expect steps 3 then 1, intermediate 0001, rsp_data=0000.
- Shift left, amount 0, data 1010: expect no STEP cycle, rsp_valid in the cycle after acceptance, rsp_data=1010, bs_shift_value stays 0.
- Rotate right, amount 15, data 0110: expect 5 STEP cycles (3,3,3,3,3) and rsp_data=1100.
- Backpressure:
  - Hold rsp_ready=0 for 4 cycles with a second req_valid pending.
  - Expect rsp_valid and rsp_data stable and req_ready=0 throughout.
  - After rsp_ready=1, expect IDLE, then the second request accepted on the following edge.
- Reset in STEP during a rotate-left-9:
  - Pulse rst_n low between clock edges.
  - Expect state IDLE immediately, rsp_valid=0, work=0000, req_ready=1.
  - Expect no response for the aborted request after release.
